stack_access_arbiter: RTL and testbench
=======================================

// Module: stack_access_arbiter
// PURPOSE
//  Shares the 5-entry x 4-bit hardware stack between NREQ requesters and sequences every stack op.
//  Requesters use valid/ready on request and response; the block issues one stack COMMAND/INDEX per op.
//  It tracks occupancy and rejects overflow, underflow and out-of-range get before they reach the stack.
//  It sits between the requester fabric and stack_structural_normal; the top level builds the tristate IO_DATA.
// PARAMETERS
//  NREQ    2  number of requesters (2..4)
//  DATA_W  4  stack data width
//  DEPTH   5  stack entries
//  IDX_W   3  get-index width
// PORTS
//  CLK          in   1          single clock; all state updates on its rising edge
//  RESET        in   1          synchronous, active-high; also wired to the stack RESET
//  req_valid    in   NREQ       per-requester request valid
//  req_cmd      in   2*NREQ     per-requester command: 00 nop, 01 pop, 10 push, 11 get
//  req_index    in   IDX_W*NREQ per-requester get index (0 = top of stack)
//  req_wdata    in   DATA_W*NREQ per-requester push data
//  req_ready    out  NREQ       one-hot grant; request accepted when valid&ready
//  rsp_valid    out  1          response valid
//  rsp_id       out  clog2(NREQ) requester that owns the response
//  rsp_data     out  DATA_W     pop/get data; 0 for push, nop and errors
//  rsp_err      out  1          1 = rejected (overflow/underflow/index range)
//  rsp_ready    in   1          response accepted when rsp_valid&rsp_ready
//  stk_cmd      out  2          stack COMMAND
//  stk_index    out  3          stack INDEX
//  stk_wdata    out  DATA_W     data to drive onto IO_DATA for push
//  stk_wdata_oe out  1          1 = top level drives IO_DATA with stk_wdata
//  stk_rdata    in   DATA_W     IO_DATA as seen by the stack's read side
//  count        out  3          current occupancy 0..DEPTH
//  full, empty  out  1          count==DEPTH, count==0
// BEHAVIOUR
//  Reset: state IDLE; count=0; rr pointer=0; all req_ready=0; rsp_valid=0; rsp_*=0; stk_cmd=00; stk_index=0; stk_wdata_oe=0.
//  FSM IDLE -> ISSUE -> RESP -> IDLE. The direct path IDLE -> RESP is used for nop and for errors.
//  IDLE:
//   - Round-robin pick among the valid requesters, starting at the rr pointer.
//   - req_ready is asserted combinationally to the winner only, and only in IDLE.
//   - On accept: latch cmd, index, wdata and id; rr pointer <= winner+1 mod NREQ.
//  Checks on accept, all against the count at the accept cycle:
//   - push with count==DEPTH -> err.
//   - pop with count==0 -> err.
//   - get with index>=count -> err.
//   - Any err: go to RESP with rsp_err=1 and rsp_data=0; no stack command; count unchanged.
//   - nop: go to RESP with rsp_err=0 and rsp_data=0; no stack command.
//  ISSUE (exactly 1 cycle):
//   - stk_cmd = latched cmd; stk_index = index (get only, else 0).
//   - push: stk_wdata_oe=1 and stk_wdata valid for the whole cycle.
//   - pop/get: stk_rdata is sampled into rsp_data at the end of the cycle.
//   - Count updates at the end of ISSUE: push +1, pop -1, get unchanged.
//  RESP:
//   - rsp_valid=1 with rsp_id/rsp_data/rsp_err held stable until rsp_ready.
//   - Handshake -> IDLE.
//  Outside ISSUE: stk_cmd=00, stk_wdata_oe=0, so the stack sees nop and IO_DATA is not driven by us.
//  Latency: accept at cycle N; valid op gives rsp_valid from N+2; err/nop gives rsp_valid from N+1.
//  Throughput: at most one op per 3 cycles (2 for err/nop) with rsp_ready tied high.
//  Simultaneous valids: exactly one grant per IDLE cycle. A losing requester holds valid; with NREQ=2 it is served next.
//  LIFO order: get index 0 returns the most recent push, index k the k-th below it. Stack address wrap is never exercised since count never exceeds DEPTH.
//  RESET mid-op: abort immediately to reset values. Any pending response is dropped and any in-flight push is lost (stack resets too).
//  req_* may change freely while req_ready=0; the latched copy is used after accept.
// STRUCTURE
//  Package stack_ctrl_pkg:
//   - stk_cmd_e: CMD_NOP=2'b00, CMD_POP=2'b01, CMD_PUSH=2'b10, CMD_GET=2'b11.
//   - arb_state_e: IDLE, ISSUE, RESP.
//   - localparams STK_DEPTH=5, STK_DATA_W=4.
//  One sub-module: rr_arbiter (NREQ-wide, pointer + enable in, one-hot grant out).
//  Everything else (FSM, checks, count, response regs) lives in the top module.
// TESTING
//  1. RESET held 2 cycles, then released -> count=0, empty=1, rsp_valid=0, stk_cmd=00 on every cycle.
//  2. Req0 pushes 1,2,3,4,5 -> five rsp_err=0 responses, count=5, full=1. Sixth push of 6 -> rsp_err=1, stk_cmd stays 00, count=5.
//  3. After test 2, Req1: pop x5 -> rsp_data 5,4,3,2,1. Sixth pop -> rsp_err=1, empty=1.
//  4. Push A,B,C; get idx0 -> C; get idx2 -> A; get idx3 -> err. Count stays 3 throughout.
//  5. Req0 and Req1 valid together continuously, push from both -> grants alternate 0,1,0,1. rsp_id matches each grant.
//  6. rsp_ready=0 for 4 cycles -> rsp fields stable, req_ready=0. RESET during ISSUE of a push -> next cycle count=0, rsp_valid=0, stk_cmd=00.

Source files
------------

// File: rtl/stack_ctrl_pkg.sv
// Shared types and sizes for the stack access arbiter.
// Command encoding matches the stack COMMAND input.
package stack_ctrl_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_POP  = 2'b01,
    CMD_PUSH = 2'b10,
    CMD_GET  = 2'b11
  } stk_cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } arb_state_e;

  localparam int STK_DEPTH  = 5;
  localparam int STK_DATA_W = 4;

endpackage

// File: rtl/stack_access_arbiter_rr.sv
// Round-robin arbiter: one-hot grant, search starts at ptr.
// Ports: en, req[N], ptr -> gnt[N] (all zero when en=0).
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = $clog2(N)
) (
  input  logic          en,
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      j = (int'(ptr) + i) % N;
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stack_access_arbiter.sv
// Shares one hardware stack between NREQ requesters.
// Ports: req_* / rsp_* handshakes, stk_* stack side, count/full/empty.
module stack_access_arbiter
  import stack_ctrl_pkg::*;
#(
  parameter  int NREQ   = 2,
  parameter  int DATA_W = STK_DATA_W,
  parameter  int DEPTH  = STK_DEPTH,
  parameter  int IDX_W  = 3,
  localparam int ID_W   = $clog2(NREQ)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [2*NREQ-1:0]        req_cmd,
  input  logic [IDX_W*NREQ-1:0]    req_index,
  input  logic [DATA_W*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  input  logic                     rsp_ready,
  output logic [1:0]               stk_cmd,
  output logic [2:0]               stk_index,
  output logic [DATA_W-1:0]        stk_wdata,
  output logic                     stk_wdata_oe,
  input  logic [DATA_W-1:0]        stk_rdata,
  output logic [2:0]               count,
  output logic                     full,
  output logic                     empty
);

  arb_state_e        state;
  stk_cmd_e          l_cmd;
  stk_cmd_e          stk_cmd_q;
  stk_cmd_e          win_cmd;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   l_id;
  logic [ID_W-1:0]   win_id;
  logic [ID_W-1:0]   nxt_ptr;
  logic [IDX_W-1:0]  win_idx;
  logic [DATA_W-1:0] win_wdata;
  logic [NREQ-1:0]   gnt;
  logic              acc;
  logic              acc_err;

  rr_arbiter #(.N(NREQ)) u_rr (
    .en  (state == IDLE && !RESET),
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign acc       = |gnt;
  assign stk_cmd   = stk_cmd_q;
  assign full      = (count == 3'(DEPTH));
  assign empty     = (count == 3'd0);

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NREQ; i++)
      if (gnt[i]) win_id = ID_W'(i);
  end

  assign win_cmd   = stk_cmd_e'(req_cmd[win_id*2 +: 2]);
  assign win_idx   = req_index[win_id*IDX_W +: IDX_W];
  assign win_wdata = req_wdata[win_id*DATA_W +: DATA_W];
  assign nxt_ptr   = (win_id == ID_W'(NREQ-1)) ? '0 : win_id + 1'b1;

  // Checks use the occupancy at the accept cycle.
  always_comb begin
    acc_err = 1'b0;
    case (win_cmd)
      CMD_PUSH: acc_err = (count == 3'(DEPTH));
      CMD_POP:  acc_err = (count == 3'd0);
      CMD_GET:  acc_err = (int'(win_idx) >= int'(count));
      default:  acc_err = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      count        <= '0;
      rr_ptr       <= '0;
      l_cmd        <= CMD_NOP;
      l_id         <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      stk_cmd_q    <= CMD_NOP;
      stk_index    <= '0;
      stk_wdata    <= '0;
      stk_wdata_oe <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (acc) begin
            rr_ptr <= nxt_ptr;
            l_cmd  <= win_cmd;
            l_id   <= win_id;
            if (acc_err || win_cmd == CMD_NOP) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_id    <= win_id;
              rsp_data  <= '0;
              rsp_err   <= acc_err;
            end else begin
              state        <= ISSUE;
              stk_cmd_q    <= win_cmd;
              stk_index    <= (win_cmd == CMD_GET) ? 3'(win_idx) : 3'd0;
              stk_wdata    <= win_wdata;
              stk_wdata_oe <= (win_cmd == CMD_PUSH);
            end
          end
        end
        ISSUE: begin
          state        <= RESP;
          stk_cmd_q    <= CMD_NOP;
          stk_index    <= '0;
          stk_wdata    <= '0;
          stk_wdata_oe <= 1'b0;
          rsp_valid    <= 1'b1;
          rsp_id       <= l_id;
          rsp_err      <= 1'b0;
          rsp_data     <= (l_cmd == CMD_POP || l_cmd == CMD_GET)
                          ? stk_rdata : '0;
          if (l_cmd == CMD_PUSH) count <= count + 3'd1;
          if (l_cmd == CMD_POP)  count <= count - 3'd1;
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_access_arbiter.sv
// Bench for stack_access_arbiter: behavioural stack, op table,
// response scoreboard and hand-written arbitration/stall/reset cases.
module tb_stack_access_arbiter;

  logic       clk = 1'b0;
  logic       RESET;
  logic [1:0] req_valid;
  logic [3:0] req_cmd;
  logic [5:0] req_index;
  logic [7:0] req_wdata;
  logic [1:0] req_ready;
  logic       rsp_valid;
  logic [0:0] rsp_id;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       rsp_ready;
  logic [1:0] stk_cmd;
  logic [2:0] stk_index;
  logic [3:0] stk_wdata;
  logic       stk_wdata_oe;
  logic [3:0] stk_rdata;
  logic [2:0] count;
  logic       full;
  logic       empty;

  always #5 clk = ~clk;

  stack_access_arbiter dut (
    .CLK(clk), .RESET(RESET),
    .req_valid(req_valid), .req_cmd(req_cmd),
    .req_index(req_index), .req_wdata(req_wdata),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .rsp_ready(rsp_ready),
    .stk_cmd(stk_cmd), .stk_index(stk_index),
    .stk_wdata(stk_wdata), .stk_wdata_oe(stk_wdata_oe),
    .stk_rdata(stk_rdata),
    .count(count), .full(full), .empty(empty)
  );

  localparam logic [1:0] NOP = 2'b00, POP = 2'b01,
                         PUSH = 2'b10, GET = 2'b11;

  int checks = 0;
  int errors = 0;
  int ncmd   = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d @%0t", nm, act, exp, $time);
    end
  endtask

  // behavioural stack: read is combinational during the ISSUE cycle
  logic [3:0] smem [8];
  int sp;
  always @(posedge clk) begin
    if (RESET) sp <= 0;
    else if (stk_cmd == PUSH) begin
      smem[sp & 7] <= stk_wdata;
      sp <= sp + 1;
    end else if (stk_cmd == POP) sp <= sp - 1;
  end
  always_comb begin
    stk_rdata = 4'h0;
    if (stk_cmd == POP) stk_rdata = smem[(sp - 1) & 7];
    if (stk_cmd == GET) stk_rdata = smem[(sp - 1 - int'(stk_index)) & 7];
  end

  always @(negedge clk) if (stk_cmd != NOP) ncmd++;

  // scoreboard
  typedef struct {
    int         id;
    logic [3:0] data;
    logic       err;
  } exp_t;
  exp_t sbq[$];

  always @(negedge clk) begin
    if (!RESET && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_err", rsp_err, e.err);
      end
    end
  end

  task automatic do_op(int id, logic [1:0] cmd, logic [2:0] idx,
                       logic [3:0] wd, logic [3:0] xd, logic xe);
    bit got = 0;
    @(negedge clk);
    req_valid[id] = 1'b1;
    req_cmd[id*2 +: 2] = cmd;
    req_index[id*3 +: 3] = idx;
    req_wdata[id*4 +: 4] = wd;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      if (req_ready[id]) begin
        got = 1;
        sbq.push_back('{id, xd, xe});
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        req_cmd[id*2 +: 2] = $urandom_range(3);
        req_index[id*3 +: 3] = $urandom_range(7);
      end else @(negedge clk);
    end
    if (!got) begin
      chk("accept_timeout", 0, 1);
      req_valid[id] = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sbq.size() != 0; i++) @(negedge clk);
    chk("drain", sbq.size(), 0);
    @(negedge clk);
  endtask

  typedef struct {
    int         id;
    logic [1:0] cmd;
    logic [2:0] idx;
    logic [3:0] wd;
    logic [3:0] xd;
    logic       xe;
    int         xcnt;
  } vec_t;
  vec_t tbl[22];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int n0, g, w;
    int served[2];

    tbl = '{
      '{0, PUSH, 0, 4'h1, 0, 0, 1}, '{0, PUSH, 0, 4'h2, 0, 0, 2},
      '{0, PUSH, 0, 4'h3, 0, 0, 3}, '{0, PUSH, 0, 4'h4, 0, 0, 4},
      '{0, PUSH, 0, 4'h5, 0, 0, 5}, '{0, PUSH, 0, 4'h6, 0, 1, 5},
      '{1, POP,  0, 4'h0, 5, 0, 4}, '{1, POP,  0, 4'h0, 4, 0, 3},
      '{1, POP,  0, 4'h0, 3, 0, 2}, '{1, POP,  0, 4'h0, 2, 0, 1},
      '{1, POP,  0, 4'h0, 1, 0, 0}, '{1, POP,  0, 4'h0, 0, 1, 0},
      '{1, GET,  0, 4'h0, 0, 1, 0}, '{0, PUSH, 0, 4'hA, 0, 0, 1},
      '{0, PUSH, 0, 4'hB, 0, 0, 2}, '{0, PUSH, 0, 4'hC, 0, 0, 3},
      '{0, GET,  0, 4'h0, 4'hC, 0, 3}, '{0, GET, 2, 4'h0, 4'hA, 0, 3},
      '{0, GET,  3, 4'h0, 0, 1, 3}, '{1, GET,  1, 4'h0, 4'hB, 0, 3},
      '{1, NOP,  5, 4'hF, 0, 0, 3}, '{0, GET,  7, 4'h0, 0, 1, 3}
    };

    // reset held two cycles, then idle
    RESET = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    req_cmd = {PUSH, PUSH};
    req_index = '0;
    req_wdata = 8'h21;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_stk_cmd", stk_cmd, 0);
    end
    req_valid = 2'b00;
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_count", count, 0);
      chk("idle_empty", empty, 1);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_stk_cmd", stk_cmd, 0);
      chk("idle_oe", stk_wdata_oe, 0);
    end

    // push to full, pop to empty, LIFO get and range checks
    foreach (tbl[k]) begin
      n0 = ncmd;
      do_op(tbl[k].id, tbl[k].cmd, tbl[k].idx, tbl[k].wd,
            tbl[k].xd, tbl[k].xe);
      drain();
      chk("tbl_count", count, tbl[k].xcnt);
      chk("tbl_full", full, tbl[k].xcnt == 5);
      chk("tbl_empty", empty, tbl[k].xcnt == 0);
      chk("tbl_stk_issue", ncmd - n0,
          (tbl[k].cmd != NOP && !tbl[k].xe) ? 1 : 0);
    end

    // both requesters pushing continuously: grants alternate
    @(negedge clk) RESET = 1'b1;
    @(negedge clk) RESET = 1'b0;
    sbq.delete();
    served = '{0, 0};
    g = 0;
    req_cmd = {PUSH, PUSH};
    req_wdata = {4'h2, 4'h1};
    req_valid = 2'b11;
    for (int c = 0; c < 60 && g < 4; c++) begin
      #1;
      if (req_ready != 2'b00) begin
        w = req_ready[1] ? 1 : 0;
        chk("grant_order", req_ready, 1 << (g % 2));
        sbq.push_back('{g % 2, 4'h0, 1'b0});
        @(posedge clk);
        #1;
        served[w]++;
        g++;
        if (served[w] == 2) req_valid[w] = 1'b0;
        else req_wdata[w*4 +: 4] = (w == 0) ? 4'h3 : 4'h4;
      end else @(negedge clk);
    end
    chk("grant_count", g, 4);
    req_valid = 2'b00;
    drain();
    chk("rr_count", count, 4);
    do_op(0, GET, 0, 0, 4'h4, 0);
    drain();
    do_op(1, GET, 3, 0, 4'h1, 0);
    drain();

    // response stall: fields hold, no new grant
    rsp_ready = 1'b0;
    do_op(1, POP, 0, 0, 4'h4, 0);
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    chk("stall_rsp_seen", rsp_valid, 1);
    req_valid[0] = 1'b1;
    req_cmd[1:0] = PUSH;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_id", rsp_id, 1);
      chk("stall_data", rsp_data, 4);
      chk("stall_err", rsp_err, 0);
      chk("stall_ready", req_ready, 0);
    end
    req_valid[0] = 1'b0;
    rsp_ready = 1'b1;
    drain();
    chk("stall_count", count, 3);

    // reset while a push is in ISSUE
    @(negedge clk);
    req_cmd[1:0] = PUSH;
    req_wdata[3:0] = 4'h9;
    req_valid[0] = 1'b1;
    g = 0;
    for (int i = 0; i < 20 && g == 0; i++) begin
      #1;
      if (req_ready[0]) begin
        g = 1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
      end else @(negedge clk);
    end
    chk("abort_accept", g, 1);
    @(negedge clk);
    chk("abort_issue_cmd", stk_cmd, PUSH);
    chk("abort_issue_oe", stk_wdata_oe, 1);
    chk("abort_issue_wdata", stk_wdata, 9);
    RESET = 1'b1;
    @(negedge clk);
    chk("abort_count", count, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_stk_cmd", stk_cmd, 0);
    chk("abort_oe", stk_wdata_oe, 0);
    RESET = 1'b0;
    sbq.delete();

    // service resumes after reset
    do_op(1, PUSH, 0, 4'h7, 0, 0);
    drain();
    do_op(0, POP, 0, 0, 4'h7, 0);
    drain();
    chk("final_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
